// File: rtl/conv_pe_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_if
// Brief    : Beat-in / result-out handshake bundle for conv_pe_pipe.
// Revision : 1.0
// ============================================================================
interface conv_pe_if #(
    parameter int TAPS = 25,
    parameter int DW   = 8,
    parameter int ACCW = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [TAPS*DW-1:0]   in_if;
    logic [TAPS*DW-1:0]   in_w;
    logic                 msb_ctrl;
    logic                 first;
    logic                 last;
    logic [ACCW-1:0]      psum;
    logic                 relu_en;
    logic                 quan_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACCW-1:0]      pe_out;

    modport master (
        output in_valid, in_if, in_w, msb_ctrl, first, last, psum, relu_en, quan_en, out_ready,
        input  in_ready, out_valid, pe_out
    );

    modport slave (
        input  in_valid, in_if, in_w, msb_ctrl, first, last, psum, relu_en, quan_en, out_ready,
        output in_ready, out_valid, pe_out
    );
endinterface
`default_nettype wire

// File: rtl/conv_pe_pipe.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_pipe
// Brief    : Two-stage TAPS-lane MAC with group accumulation, ReLU and 8-bit
//            quantisation. Define PE_SAT_ACC_EN for a saturating accumulate
//            and a sticky sat_flag output.
// Revision : 1.0
// ============================================================================
module conv_pe_pipe #(
    parameter int TAPS   = 25,
    parameter int DW     = 8,
    parameter int ACCW   = 32,
    parameter int QSHIFT = 7
) (
    input  logic clk,
    input  logic rst,
`ifdef PE_SAT_ACC_EN
    output logic sat_flag,
`endif
    conv_pe_if.slave bus
);

    logic                   w_stall;
    logic                   w_accept;
    logic signed [ACCW-1:0] w_prod [TAPS];
    logic signed [ACCW-1:0] r_prod [TAPS];
    logic                   r_s1_valid;
    logic                   r_s1_first;
    logic                   r_s1_last;
    logic                   r_s1_relu;
    logic                   r_s1_quan;
    logic signed [ACCW-1:0] r_s1_psum;
    logic signed [ACCW-1:0] r_acc;
    logic [ACCW-1:0]        r_pe_out;
    logic                   r_out_valid;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_base;
    logic signed [ACCW-1:0] w_acc_next;
    logic [ACCW-1:0]        w_r;
    logic [ACCW-1:0]        w_post;
    logic                   w_rnd;

    assign w_stall       = r_out_valid && !bus.out_ready;
    assign w_accept      = bus.in_valid && !w_stall;
    assign bus.in_ready  = !w_stall;
    assign bus.out_valid = r_out_valid;
    assign bus.pe_out    = r_pe_out;

    generate
        for (genvar j = 0; j < TAPS; j++) begin : g_lane
            logic [DW-1:0]          w_f;
            logic [DW-1:0]          w_w;
            logic signed [ACCW-1:0] w_fx;
            logic signed [ACCW-1:0] w_wx;
            assign w_f = bus.in_if[j*DW +: DW];
            assign w_w = bus.in_w[j*DW +: DW];
            // Feature is DW+1 bits; its top bit copies the lane MSB only in signed mode.
            assign w_fx = $signed({{(ACCW-DW){bus.msb_ctrl & w_f[DW-1]}}, w_f});
            assign w_wx = $signed({{(ACCW-DW){w_w[DW-1]}}, w_w});
            assign w_prod[j] = w_fx * w_wx;
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < TAPS; j++) begin
            w_sum = w_sum + r_prod[j];
        end
    end

    assign w_base = r_s1_first ? r_s1_psum : r_acc;

`ifdef PE_SAT_ACC_EN
    logic [ACCW:0] w_wide;
    logic          w_ovf;
    logic          r_sat;
    assign w_wide     = {w_base[ACCW-1], w_base} + {w_sum[ACCW-1], w_sum};
    assign w_ovf      = w_wide[ACCW] ^ w_wide[ACCW-1];
    assign w_acc_next = !w_ovf ? $signed(w_wide[ACCW-1:0])
                      : (w_wide[ACCW] ? $signed({1'b1, {(ACCW-1){1'b0}}})
                                      : $signed({1'b0, {(ACCW-1){1'b1}}}));
    assign sat_flag   = r_sat;

    // A saturation in stage 2 outranks a clear from a new group entering stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (!w_stall) begin
            if (r_s1_valid && w_ovf) begin
                r_sat <= 1'b1;
            end else if (bus.in_valid && bus.first) begin
                r_sat <= 1'b0;
            end
        end
    end
`else
    assign w_acc_next = w_base + w_sum;
`endif

    assign w_r = (r_s1_relu && w_acc_next[ACCW-1]) ? '0 : w_acc_next;

    generate
        if (QSHIFT > 0) begin : g_rnd
            assign w_rnd = w_r[QSHIFT-1];
        end else begin : g_no_rnd
            assign w_rnd = 1'b0;
        end
    endgenerate

    always_comb begin
        w_post = w_r;
        if (r_s1_quan) begin
            if (w_r[ACCW-1]) begin
                w_post = '0;
            end else if (|w_r[ACCW-1:QSHIFT+8]) begin
                w_post = ACCW'(255);
            end else if (&w_r[QSHIFT+7:QSHIFT]) begin
                w_post = ACCW'(255);
            end else begin
                w_post = ACCW'(w_r[QSHIFT+7:QSHIFT]) + ACCW'(w_rnd);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < TAPS; j++) begin
                r_prod[j] <= '0;
            end
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_relu   <= 1'b0;
            r_s1_quan   <= 1'b0;
            r_s1_psum   <= '0;
            r_acc       <= '0;
            r_pe_out    <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                for (int j = 0; j < TAPS; j++) begin
                    r_prod[j] <= w_prod[j];
                end
                r_s1_first <= bus.first;
                r_s1_last  <= bus.last;
                r_s1_relu  <= bus.relu_en;
                r_s1_quan  <= bus.quan_en;
                r_s1_psum  <= bus.psum;
            end
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
            end
            if (r_s1_valid && r_s1_last) begin
                r_pe_out    <= w_post;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/conv_pe_pipe.md
CONV_PE_PIPE -- requirements
Module: conv_pe_pipe

Interface
REQ-001 Parameter TAPS, default 25: number of multiply lanes (kernel taps) per beat.
REQ-002 Parameter DW, default 8: feature and weight element width.
REQ-003 Parameter ACCW, default 32: accumulator and pe_out width; ACCW ≥ 2*DW+1+clog2(TAPS+1).
REQ-004 Parameter QSHIFT, default 7: quantisation right shift; QSHIFT+8 ≤ ACCW-1.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block can accept a beat.
REQ-009 in_if  in  TAPS*DW  feature lanes, lane j at bits [j*DW+DW-1 : j*DW].
REQ-010 in_w  in  TAPS*DW  signed weight lanes, same packing.
REQ-011 msb_ctrl  in  1  1 = feature lanes signed, 0 = unsigned (zero-extended).
REQ-012 first  in  1  beat starts a new accumulation group; accumulator seeds from psum.
REQ-013 last  in  1  beat ends the group; result is emitted.
REQ-014 psum  in  ACCW  signed partial sum, added only on a first beat.
REQ-015 relu_en  in  1  clamp negative results to 0.
REQ-016 quan_en  in  1  quantise the result to 8 bits.
REQ-017 out_valid  out  1  pe_out holds a result.
REQ-018 out_ready  in  1  downstream accepts the result.
REQ-019 pe_out  out  ACCW  result; 8-bit value zero-extended when quantised.

Function
REQ-020 A beat is accepted when in_valid && in_ready at a rising edge; msb_ctrl, first, last, psum, relu_en and quan_en are sampled with the beat and pipelined with it.
REQ-021 Stage 1 registers TAPS products: (DW+1)-bit feature (MSB = msb_ctrl ? lane MSB : 0) times signed weight, sign-extended to ACCW.
REQ-022 Stage 2 forms sum = adder-tree total of all products; acc_next = (first ? psum : acc) + sum, in ACCW-bit two's-complement arithmetic that wraps on overflow; acc <= acc_next.
REQ-023 On a last beat, stage 2 also loads pe_out <= post(acc_next) and sets out_valid; latency is 2 rising edges from acceptance to out_valid.
REQ-024 post(): r = relu_en && acc_next<0 ? 0 : acc_next; if quan_en: r<0 -> 0; any bit of r[ACCW-1:QSHIFT+8] set -> 255; r[QSHIFT+7:QSHIFT] == 255 -> 255; else r[QSHIFT+7:QSHIFT] + r[QSHIFT-1], where the rounding bit is 0 when QSHIFT == 0.
REQ-025 first and last on the same beat form a single-beat group: pe_out = post(psum + sum).
REQ-026 A beat without first that follows reset or a completed group accumulates onto the current acc value, which is not cleared by last.
REQ-027 stall = out_valid && !out_ready; in_ready = !stall; while stall is high both stages, acc, pe_out and out_valid hold.
REQ-028 out_valid clears on an edge with out_valid && out_ready unless a new last result loads on the same edge; a back-to-back last beat then replaces pe_out with no bubble.
REQ-029 Pipeline valid bits track beats; a non-last beat never asserts out_valid.

Reset
REQ-030 rst high clears all product registers, stage valid bits, acc, pe_out and out_valid to 0 immediately; in_ready is 1 after reset.
REQ-031 A group in flight when reset asserts is discarded; no partial result is emitted after reset.

Configuration
REQ-032 With macro PE_SAT_ACC_EN defined, the stage-2 addition saturates to the signed ACCW maximum or minimum instead of wrapping, and the block adds output sat_flag (1 bit), which is sticky after a saturation and cleared by rst or an accepted first beat; without the macro, the addition wraps and sat_flag does not exist.

Verification
REQ-033 Defaults, all features 1, weights 1, msb_ctrl=0, psum=0, first=last=1, relu/quan off -> pe_out=25 two edges after acceptance.
REQ-034 Features 0xFF, weights 1: msb_ctrl=1 -> pe_out=-25 (0xFFFFFFE7), relu_en=1 -> 0, msb_ctrl=0 -> 6375.
REQ-035 Three beats, first on beat 0, last on beat 2, each sum 100, psum=5 -> a single out_valid with pe_out=305.
REQ-036 quan_en=1, QSHIFT=7: acc 0x3FC0 -> 128 (127+1 round); 0x7FFF -> 255; 0x8000 -> 255; -1 -> 0.
REQ-037 out_ready held 0 for 5 cycles with out_valid=1 -> in_ready=0, pe_out stable; release -> queued beats resume with no loss or duplication.
REQ-038 rst asserted between beat 1 and beat 2 of a group -> outputs 0 immediately, no out_valid; with PE_SAT_ACC_EN, psum=0x7FFFFFF0 plus sum 100 -> 0x7FFFFFFF and sat_flag=1.
